// File: rtl/mdr_mem_ctrl.sv
// Memory Data Register with single-word RAM read/write handshake controller.
// Optional wait-state timeout is enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MDRin,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] MDR_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mdr_q, mdr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    in_wait;
    logic                    timeout_hit;

    assign in_wait = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is zero whenever a WAIT state is entered, so it counts wait cycles.
    always_comb begin
        cnt_d       = in_wait ? cnt_q + 1'b1 : '0;
        timeout_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clock) begin
        if (clear) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_read)       state_d = S_RD_WAIT;
                else if (mem_write) state_d = S_WR_WAIT;
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (mem_ack || timeout_hit) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mdr_d   = mdr_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        req_d   = req_q;
        we_d    = we_q;
        error_d = error_q;
        done_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (MDRin) mdr_d = BusMuxOut;
                // Read has priority; a write in the same cycle is dropped.
                if (mem_read) begin
                    addr_d  = addr_in;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    error_d = 1'b0;
                end else if (mem_write) begin
                    addr_d  = addr_in;
                    wdata_d = mdr_q;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    error_d = 1'b0;
                end
            end
            S_RD_WAIT: begin
                if (mem_ack) begin
                    mdr_d  = mem_rdata;
                    req_d  = 1'b0;
                    done_d = 1'b1;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            S_WR_WAIT: begin
                if (mem_ack) begin
                    req_d  = 1'b0;
                    we_d   = 1'b0;
                    done_d = 1'b1;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            mdr_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            mdr_q   <= mdr_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign MDR_out   = mdr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Directed, table-driven bench for mdr_mem_ctrl; extra sequences cover
// mid-transaction clear, bounded ack wait and the MDR_TIMEOUT_EN variant.
module tb_mdr_mem_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] BusMuxOut;
    logic        MDRin;
    logic [8:0]  addr_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] MDR_out;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    mdr_mem_ctrl dut (
        .clock     (clock),
        .clear     (clear),
        .BusMuxOut (BusMuxOut),
        .MDRin     (MDRin),
        .addr_in   (addr_in),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .MDR_out   (MDR_out),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        clr;
        logic        mdrin;
        logic [31:0] bus;
        logic [8:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] rdata;
        logic        ack;
        logic        e_req;
        logic        e_we;
        logic [8:0]  e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_mdr;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic clr, input logic mdrin,
                                input logic [31:0] bus, input logic [8:0] addr,
                                input logic rd, input logic wr, input logic [31:0] rdata,
                                input logic ack, input logic e_req, input logic e_we,
                                input logic [8:0] e_addr, input logic [31:0] e_wdata,
                                input logic [31:0] e_mdr, input logic e_busy,
                                input logic e_done);
        vec_t v;
        v.name = nm; v.clr = clr; v.mdrin = mdrin; v.bus = bus; v.addr = addr;
        v.rd = rd; v.wr = wr; v.rdata = rdata; v.ack = ack;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_mdr = e_mdr; v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic clr, input logic mdrin, input logic [31:0] bus,
                         input logic [8:0] addr, input logic rd, input logic wr,
                         input logic [31:0] rdata, input logic ack);
        clear = clr; MDRin = mdrin; BusMuxOut = bus; addr_in = addr;
        mem_read = rd; mem_write = wr; mem_rdata = rdata; mem_ack = ack;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got_done;

        //               name        clr md bus           addr    rd wr rdata         ack req we e_addr  e_wdata       e_mdr         bsy dn
        vecs.push_back(mk("rst0",     1, 0, 32'h0,        9'h000, 0, 0, 32'h0,        0,  0, 0, 9'h000, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk("rst1",     1, 0, 32'h0,        9'h000, 0, 0, 32'h0,        0,  0, 0, 9'h000, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk("load",     0, 1, 32'hDEADBEEF, 9'h000, 0, 0, 32'h0,        0,  0, 0, 9'h000, 32'h0,        32'hDEADBEEF, 0, 0));
        vecs.push_back(mk("idle",     0, 0, 32'h0,        9'h000, 0, 0, 32'h0,        0,  0, 0, 9'h000, 32'h0,        32'hDEADBEEF, 0, 0));
        vecs.push_back(mk("rd_req",   0, 0, 32'h0,        9'h005, 1, 0, 32'h0,        0,  1, 0, 9'h005, 32'h0,        32'hDEADBEEF, 1, 0));
        vecs.push_back(mk("rd_w1",    0, 0, 32'h0,        9'h000, 0, 0, 32'h0,        0,  1, 0, 9'h005, 32'h0,        32'hDEADBEEF, 1, 0));
        vecs.push_back(mk("rd_w2",    0, 0, 32'h0,        9'h000, 0, 0, 32'h0,        0,  1, 0, 9'h005, 32'h0,        32'hDEADBEEF, 1, 0));
        vecs.push_back(mk("rd_ack",   0, 0, 32'h0,        9'h000, 0, 0, 32'h12345678, 1,  0, 0, 9'h005, 32'h0,        32'h12345678, 1, 1));
        vecs.push_back(mk("rd_idle",  0, 0, 32'h0,        9'h000, 0, 0, 32'h0,        0,  0, 0, 9'h005, 32'h0,        32'h12345678, 0, 0));
        vecs.push_back(mk("idle_ack", 0, 0, 32'h0,        9'h000, 0, 0, 32'hFFFFFFFF, 1,  0, 0, 9'h005, 32'h0,        32'h12345678, 0, 0));
        vecs.push_back(mk("load_a5",  0, 1, 32'hA5A5A5A5, 9'h000, 0, 0, 32'h0,        0,  0, 0, 9'h005, 32'h0,        32'hA5A5A5A5, 0, 0));
        vecs.push_back(mk("wr_req",   0, 1, 32'h0,        9'h1FF, 0, 1, 32'h0,        0,  1, 1, 9'h1FF, 32'hA5A5A5A5, 32'h0,        1, 0));
        vecs.push_back(mk("wr_ign",   0, 1, 32'h11111111, 9'h003, 1, 0, 32'h0,        0,  1, 1, 9'h1FF, 32'hA5A5A5A5, 32'h0,        1, 0));
        vecs.push_back(mk("wr_ack",   0, 0, 32'h0,        9'h000, 0, 0, 32'hCAFEF00D, 1,  0, 0, 9'h1FF, 32'hA5A5A5A5, 32'h0,        1, 1));
        vecs.push_back(mk("wr_idle",  0, 0, 32'h0,        9'h000, 0, 0, 32'h0,        0,  0, 0, 9'h1FF, 32'hA5A5A5A5, 32'h0,        0, 0));
        vecs.push_back(mk("rw_both",  0, 0, 32'h0,        9'h0AA, 1, 1, 32'h0,        0,  1, 0, 9'h0AA, 32'hA5A5A5A5, 32'h0,        1, 0));
        vecs.push_back(mk("rw_ign",   0, 0, 32'h0,        9'h033, 1, 0, 32'h0,        0,  1, 0, 9'h0AA, 32'hA5A5A5A5, 32'h0,        1, 0));
        vecs.push_back(mk("rw_ack",   0, 0, 32'h0,        9'h000, 0, 0, 32'h0BADCAFE, 1,  0, 0, 9'h0AA, 32'hA5A5A5A5, 32'h0BADCAFE, 1, 1));
        vecs.push_back(mk("done_ign", 0, 1, 32'h77777777, 9'h044, 1, 0, 32'h0,        0,  0, 0, 9'h0AA, 32'hA5A5A5A5, 32'h0BADCAFE, 0, 0));
        vecs.push_back(mk("rw_idle",  0, 0, 32'h0,        9'h000, 0, 0, 32'h0,        0,  0, 0, 9'h0AA, 32'hA5A5A5A5, 32'h0BADCAFE, 0, 0));
        vecs.push_back(mk("min_req",  0, 0, 32'h0,        9'h100, 0, 1, 32'h0,        0,  1, 1, 9'h100, 32'h0BADCAFE, 32'h0BADCAFE, 1, 0));
        vecs.push_back(mk("min_ack",  0, 0, 32'h0,        9'h000, 0, 0, 32'h0,        1,  0, 0, 9'h100, 32'h0BADCAFE, 32'h0BADCAFE, 1, 1));
        vecs.push_back(mk("min_idle", 0, 0, 32'h0,        9'h000, 0, 0, 32'h0,        0,  0, 0, 9'h100, 32'h0BADCAFE, 32'h0BADCAFE, 0, 0));

        drive(1, 0, 32'h0, 9'h0, 0, 0, 32'h0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].mdrin, vecs[i].bus, vecs[i].addr,
                  vecs[i].rd, vecs[i].wr, vecs[i].rdata, vecs[i].ack);
            step();
            chk({vecs[i].name, ".mem_req"},   32'(mem_req),   32'(vecs[i].e_req));
            chk({vecs[i].name, ".mem_we"},    32'(mem_we),    32'(vecs[i].e_we));
            chk({vecs[i].name, ".mem_addr"},  32'(mem_addr),  32'(vecs[i].e_addr));
            chk({vecs[i].name, ".mem_wdata"}, mem_wdata,      vecs[i].e_wdata);
            chk({vecs[i].name, ".MDR_out"},   MDR_out,        vecs[i].e_mdr);
            chk({vecs[i].name, ".busy"},      32'(busy),      32'(vecs[i].e_busy));
            chk({vecs[i].name, ".done"},      32'(done),      32'(vecs[i].e_done));
            chk({vecs[i].name, ".error"},     32'(error),     32'h0);
        end

        // Clear while in RD_WAIT, then a stray ack: nothing must happen.
        drive(0, 0, 32'h0, 9'h012, 1, 0, 32'h0, 0);
        step();
        chk("clr_mid.req_before", 32'(mem_req), 32'h1);
        drive(1, 0, 32'h0, 9'h0, 0, 0, 32'h0, 0);
        step();
        chk("clr_mid.req",  32'(mem_req),  32'h0);
        chk("clr_mid.mdr",  MDR_out,       32'h0);
        chk("clr_mid.addr", 32'(mem_addr), 32'h0);
        chk("clr_mid.busy", 32'(busy),     32'h0);
        drive(0, 0, 32'h0, 9'h0, 0, 0, 32'h55555555, 1);
        step();
        chk("late_ack.mdr",  MDR_out,      32'h0);
        chk("late_ack.done", 32'(done),    32'h0);
        chk("late_ack.req",  32'(mem_req), 32'h0);
        chk("late_ack.busy", 32'(busy),    32'h0);

        // Bounded wait for done with ack arriving on the fourth wait cycle.
        drive(0, 0, 32'h0, 9'h007, 1, 0, 32'h0, 0);
        step();
        got_done = 1'b0;
        for (int i = 0; i < 10 && !got_done; i++) begin
            drive(0, 0, 32'h0, 9'h0, 0, 0, 32'h600DD00D, (i == 3));
            step();
            if (done) got_done = 1'b1;
        end
        chk("ackwait.done_seen", 32'(got_done), 32'h1);
        chk("ackwait.mdr", MDR_out, 32'h600DD00D);
        drive(0, 0, 32'h0, 9'h0, 0, 0, 32'h0, 0);
        step();
        chk("ackwait.idle", 32'(busy), 32'h0);

`ifdef MDR_TIMEOUT_EN
        drive(0, 0, 32'h0, 9'h009, 1, 0, 32'h0, 0);
        step();
        drive(0, 0, 32'h0, 9'h0, 0, 0, 32'h0, 0);
        for (int k = 1; k < 16; k++) step();
        chk("to.req_at15",   32'(mem_req), 32'h1);
        chk("to.err_at15",   32'(error),   32'h0);
        step();
        chk("to.req",   32'(mem_req), 32'h0);
        chk("to.error", 32'(error),   32'h1);
        chk("to.done",  32'(done),    32'h1);
        chk("to.mdr",   MDR_out,      32'h600DD00D);
        step();
        chk("to.done_drop", 32'(done),  32'h0);
        chk("to.idle",      32'(busy),  32'h0);
        chk("to.err_hold",  32'(error), 32'h1);
        drive(0, 0, 32'h0, 9'h00A, 1, 0, 32'h0, 0);
        step();
        chk("to.err_clr", 32'(error),   32'h0);
        chk("to.req2",    32'(mem_req), 32'h1);
        drive(0, 0, 32'h0, 9'h0, 0, 0, 32'h00000001, 1);
        step();
        chk("to.ack2_mdr", MDR_out, 32'h00000001);
        drive(0, 0, 32'h0, 9'h0, 0, 0, 32'h0, 0);
        step();
`else
        // Without the timeout the WAIT state holds indefinitely.
        drive(0, 0, 32'h0, 9'h00F, 1, 0, 32'h0, 0);
        step();
        drive(0, 0, 32'h0, 9'h0, 0, 0, 32'h0, 0);
        for (int k = 0; k < 20; k++) step();
        chk("hold.req",   32'(mem_req), 32'h1);
        chk("hold.busy",  32'(busy),    32'h1);
        chk("hold.error", 32'(error),   32'h0);
        chk("hold.done",  32'(done),    32'h0);
        drive(0, 0, 32'h0, 9'h0, 0, 0, 32'h00000001, 1);
        step();
        chk("hold.ack_done", 32'(done), 32'h1);
        chk("hold.ack_mdr",  MDR_out,   32'h00000001);
        drive(0, 0, 32'h0, 9'h0, 0, 0, 32'h0, 0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdr_mem_ctrl.md
Name: mdr_mem_ctrl

Overview:
- Memory Data Register (MDR) plus its memory-side handshake controller.
- Sits directly downstream of the 2:1 MDR source mux and upstream of the bus. Holds the 32-bit MDR, loads it from BusMuxOut, and runs single-word read/write transactions against the RAM model.
- On a read, it supplies the word that the MDR mux selects on its memory input.
- Drives MDR contents onto the bus-side output and the memory write-data port.

Parameters:
- DATA_WIDTH, 32, width of MDR, bus and memory data.
- ADDR_WIDTH, 9, memory word-address width (512-word RAM).
- TIMEOUT_CYCLES, 16, wait-state cycles before abort; used only when MDR_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- clear  in  1  synchronous active-high reset.
- BusMuxOut  in  DATA_WIDTH  bus value; loaded into MDR when MDRin=1 in IDLE.
- MDRin  in  1  load MDR from BusMuxOut.
- addr_in  in  ADDR_WIDTH  word address (from MAR); latched at request accept.
- mem_read  in  1  start read transaction.
- mem_write  in  1  start write transaction.
- mem_rdata  in  DATA_WIDTH  RAM read data; valid when mem_ack=1.
- mem_ack  in  1  RAM completion strobe.
- mem_req  out  1  transaction request to RAM; held high until ack.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  ADDR_WIDTH  latched address.
- mem_wdata  out  DATA_WIDTH  latched MDR value for writes.
- MDR_out  out  DATA_WIDTH  current MDR contents to bus.
- busy  out  1  high in RD_WAIT, WR_WAIT and DONE.
- done  out  1  one-cycle completion pulse.
- error  out  1  timeout flag; see Optional Feature.

Behaviour:
- Reset (clear=1 at edge, from any state, including mid-transaction): state=IDLE; MDR_out, mem_req, mem_we, mem_addr, mem_wdata, busy, done and error all 0; timeout counter 0.
  - An in-flight transaction is abandoned. A late mem_ack is ignored in IDLE.
- States are IDLE, RD_WAIT, WR_WAIT and DONE. All outputs are registered.
- IDLE:
  - mem_read=1: latch addr_in into mem_addr; mem_req<=1, mem_we<=0; next state RD_WAIT.
  - Else mem_write=1: latch addr_in into mem_addr and MDR into mem_wdata; mem_req<=1, mem_we<=1; next state WR_WAIT.
  - mem_read and mem_write both 1: the read wins and the write is dropped.
  - MDRin=1 loads MDR from BusMuxOut. If MDRin coincides with mem_write, mem_wdata takes the OLD MDR value and MDR takes BusMuxOut.
  - Accepting any request clears error.
- RD_WAIT: mem_ack sampled 1 → MDR<=mem_rdata, mem_req<=0, done<=1; next state DONE.
- WR_WAIT: mem_ack sampled 1 → mem_req<=0, mem_we<=0, done<=1; next state DONE. MDR is unchanged.
- DONE: done=1 for exactly this cycle; next state IDLE with done<=0.
- Requests and MDRin are ignored in RD_WAIT, WR_WAIT and DONE. They are not queued.
- Latency, with request sampled at edge 0:
  - mem_req rises after edge 0.
  - Ack sampled at edge k (k≥1) → done and new MDR visible after edge k.
  - Module returns to IDLE after edge k+1.
  - Minimum request-to-done: 2 edges.
- mem_ack outside a WAIT state has no effect.

Optional Feature:
- Macro: MDR_TIMEOUT_EN.
- Defined: a counter increments each cycle in RD_WAIT or WR_WAIT.
  - When it reaches TIMEOUT_CYCLES with no ack: mem_req<=0, error<=1, done<=1, MDR unchanged; next state DONE.
  - The counter resets on entering any WAIT state.
  - An ack in the same cycle the limit is reached counts as success.
  - error stays high until the next accepted request or clear.
- Undefined: no counter; WAIT states hold until ack; error is tied to 0.

Test Plan:
- clear=1 for 2 cycles, then MDRin=1, BusMuxOut=0xDEADBEEF → all outputs 0 after reset; MDR_out=0xDEADBEEF one edge after load.
- mem_read=1, addr_in=0x05; RAM acks after 3 wait cycles with mem_rdata=0x12345678 → mem_req high 3 cycles, mem_we=0, mem_addr=0x05; MDR_out=0x12345678 and done=1 for exactly one cycle.
- MDR=0xA5A5A5A5, mem_write=1, addr_in=0x1FF, MDRin=1, BusMuxOut=0x0 same cycle → mem_wdata=0xA5A5A5A5, mem_we=1, MDR_out=0x0; done after ack.
- mem_read=1 and mem_write=1 same cycle; then mem_read pulsed while busy → read transaction only (mem_we=0); second request ignored, no second mem_req.
- clear=1 while in RD_WAIT, then mem_ack=1 next cycle → state IDLE, mem_req=0, MDR_out=0, no done pulse.
- (MDR_TIMEOUT_EN) read with no ack, TIMEOUT_CYCLES=16 → after 16 wait cycles mem_req=0, error=1, done pulse, MDR unchanged; error=0 after next accepted read.
